// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU and its combinational sibling.
// Opcodes, FSM states and the response bundle live here.
package alu_const;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  typedef enum logic [1:0] {
    alu_add = 2'd0,
    alu_sub = 2'd1,
    alu_sll = 2'd2,
    alu_srl = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zf;
    logic            of;
    logic            cf;
  } resp_t;

  // True for the two opcodes that go through the shift datapath
  function automatic logic is_shift(alu_op_e op);
    return (op == alu_sll) || (op == alu_srl);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between a requester and seq_alu.
// master drives requests and resp_ready; slave is the ALU.
interface seq_alu_if;
  import alu_const::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  alu_op_e         ctrl;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] res;
  logic            zf;
  logic            of;
  logic            cf;

  modport master (
    output req_valid, a, b, ctrl, resp_ready,
    input  req_ready, resp_valid, res, zf, of, cf
  );

  modport slave (
    input  req_valid, a, b, ctrl, resp_ready,
    output req_ready, resp_valid, res, zf, of, cf
  );

endinterface

// File: rtl/addsub32.sv
// 32-bit adder/subtractor with 33-bit sum.
// cf_o is carry for add and borrow (a<b unsigned) for sub.
module addsub32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        sub_i,
  output logic [31:0] sum_o,
  output logic        cf_o,
  output logic        of_o
);

  logic [31:0] b_eff;
  logic [32:0] sum33;

  // Two's-complement subtract: a + ~b + 1
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    sum33 = {1'b0, a_i} + {1'b0, b_eff}
          + {32'd0, sub_i};
  end

  assign sum_o = sum33[31:0];
  assign cf_o  = sub_i ? ~sum33[32] : sum33[32];

  // Overflow: operand signs (after negation) agree, result sign differs
  assign of_o = sub_i
    ? (a_i[31] != b_i[31]) && (sum33[31] != a_i[31])
    : (a_i[31] == b_i[31]) && (sum33[31] != a_i[31]);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub, bit-serial shifts.
// One operation in flight; response held until resp_ready.
module seq_alu
  import alu_const::*;
(
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] work_q,  work_d;
  logic [SHW-1:0]  cnt_q,   cnt_d;
  alu_op_e         op_q,    op_d;
  resp_t           rsp_q,   rsp_d;

  logic            accept;
  logic [SHW-1:0]  amt;
  logic            shift_req;
  logic [XLEN-1:0] as_sum;
  logic            as_cf;
  logic            as_of;
  logic [XLEN-1:0] step;
  logic            out_bit;
  logic            last;

  assign accept    = (state_q == S_IDLE) && bus.req_valid;
  assign amt       = bus.b[SHW-1:0];
  assign shift_req = is_shift(bus.ctrl);
  assign last      = (cnt_q == SHW'(1));

  addsub32 u_addsub (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .sub_i (bus.ctrl == alu_sub),
    .sum_o (as_sum),
    .cf_o  (as_cf),
    .of_o  (as_of)
  );

  // One-bit shift of the working register and the bit leaving it
  always_comb begin
    step    = work_q;
    out_bit = 1'b0;
    unique case (1'b1)
      (op_q == alu_sll): begin
        step    = {work_q[XLEN-2:0], 1'b0};
        out_bit = work_q[XLEN-1];
      end
      (op_q == alu_srl): begin
        step    = {1'b0, work_q[XLEN-1:1]};
        out_bit = work_q[0];
      end
      default: begin
        step    = work_q;
        out_bit = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (shift_req && (amt != '0)) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decode the state; data comes from registers
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_DONE);
    bus.res        = rsp_q.res;
    bus.zf         = rsp_q.zf;
    bus.of         = rsp_q.of;
    bus.cf         = rsp_q.cf;
  end

  // Datapath next values: capture on accept, step while shifting
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    rsp_d  = rsp_q;
    if (accept) begin
      op_d   = bus.ctrl;
      work_d = bus.a;
      cnt_d  = amt;
      if (!shift_req) begin
        rsp_d.res = as_sum;
        rsp_d.cf  = as_cf;
        rsp_d.of  = as_of;
        rsp_d.zf  = (as_sum == '0);
      end else if (amt == '0) begin
        rsp_d.res = bus.a;
        rsp_d.cf  = 1'b0;
        rsp_d.of  = 1'b0;
        rsp_d.zf  = (bus.a == '0);
      end
    end else if (state_q == S_SHIFT) begin
      work_d = step;
      cnt_d  = cnt_q - SHW'(1);
      if (last) begin
        rsp_d.res = step;
        rsp_d.cf  = out_bit;
        rsp_d.of  = 1'b0;
        rsp_d.zf  = (step == '0);
      end
    end
  end

  // Datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= alu_add;
      rsp_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      rsp_q  <= rsp_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: latency, flags, backpressure
// and reset behaviour with hand-computed expectations.
module tb_seq_alu;
  import alu_const::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_alu_if bus ();

  seq_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after accept
  task automatic accept_op(input string tag,
                           input alu_op_e op,
                           input logic [31:0] av,
                           input logic [31:0] bv);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.ctrl      = op;
    bus.a         = av;
    bus.b         = bv;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.ctrl      = alu_sub;
  endtask

  task automatic wait_resp(input string tag,
                           input int exp_lat,
                           input logic chk_busy);
    int   lat;
    logic busy_bad;
    lat      = 1;
    busy_bad = 1'b0;
    while (!bus.resp_valid && lat < 200) begin
      if (bus.req_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (chk_busy)
      chk({tag, " req_ready low"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic chk_rsp(input string tag,
                         input logic [31:0] r,
                         input logic z,
                         input logic o,
                         input logic c);
    chk({tag, " res"}, bus.res, r);
    chk({tag, " zf/of/cf"},
        32'({bus.zf, bus.of, bus.cf}),
        32'({z, o, c}));
  endtask

  task automatic retire(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, " idle after retire"},
        32'({bus.req_ready, bus.resp_valid}), 32'b10);
  endtask

  task automatic run_op(input string tag,
                        input alu_op_e op,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input int lat,
                        input logic [31:0] r,
                        input logic z,
                        input logic o,
                        input logic c);
    accept_op(tag, op, av, bv);
    wait_resp(tag, lat, 1'b0);
    chk_rsp(tag, r, z, o, c);
    retire(tag);
  endtask

  initial begin
    logic seen;
    rst            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.ctrl       = alu_add;
    bus.a          = 32'hFFFF_FFFF;
    bus.b          = 32'hFFFF_FFFF;
    bus.resp_ready = 1'b0;

    // Reset state with a request pending
    @(negedge clk);
    chk("reset hs", 32'({bus.req_ready, bus.resp_valid}), 32'b10);
    chk_rsp("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("no accept in reset", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;

    // add with carry out, accepted on first edge after reset
    accept_op("add ff+ff", alu_add, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("add ff+ff", 1, 1'b0);
    chk_rsp("add ff+ff", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    retire("add ff+ff");

    run_op("sub ff-ff", alu_sub, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           1, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("sub ff-f0", alu_sub, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
           1, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
    run_op("add ovf", alu_add, 32'h7FFF_FFFF, 32'h0000_0001,
           1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub borrow", alu_sub, 32'h0, 32'h1,
           1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("sll zero amt", alu_sll, 32'h1234_5678, 32'hFFFF_FFE0,
           1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Maximum shift
    accept_op("sll 31", alu_sll, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_resp("sll 31", 32, 1'b1);
    chk_rsp("sll 31", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    retire("sll 31");

    // Backpressure on a shift response
    accept_op("srl 4", alu_srl, 32'h8000_0000, 32'h4);
    wait_resp("srl 4", 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("srl 4 held", {bus.resp_valid, bus.res[30:0]},
          {1'b1, 31'h0800_0000});
      chk("srl 4 held top", 32'({bus.res[31], bus.cf}), 32'b00);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.ctrl       = alu_add;
    bus.a          = 32'd5;
    bus.b          = 32'd6;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("no accept on retire",
        32'({bus.req_ready, bus.resp_valid}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("late add valid", 32'(bus.resp_valid), 32'd1);
    chk("late add res", bus.res, 32'd11);
    retire("late add");

    // Reset in the middle of a shift
    accept_op("sll 20", alu_sll, 32'h1, 32'd20);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid rst hs", 32'({bus.req_ready, bus.resp_valid}), 32'b10);
    chk("mid rst res", bus.res, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    chk("no stale resp", 32'(seen), 32'd0);
    run_op("add 1+2", alu_add, 32'd1, 32'd2,
           1, 32'd3, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 The block SHALL have these ports:
- req_valid  input  1  request present.
- req_ready  output 1  block can accept a request.
- a  input  32  operand A.
- b  input  32  operand B; for shifts, only b[4:0] is the shift amount.
- ctrl  input  2  operation, one of alu_add, alu_sub, alu_sll, alu_srl.
- resp_valid  output 1  result and flags valid.
- resp_ready  input  1  consumer accepts the response.
- res  output 32  result.
- zf, of, cf  output 1 each  zero, signed overflow, and carry/borrow/shift-out flags.

Function
REQ-003 The state machine SHALL have states IDLE, SHIFT and DONE; req_ready SHALL be 1 only in IDLE.
REQ-004 A request SHALL be accepted on a rising edge with req_valid=1 in IDLE; a, b and ctrl SHALL be registered on that edge, and later changes on those inputs SHALL be ignored.
REQ-005 Transitions on acceptance:
- add or sub: IDLE->DONE.
- sll or srl with b[4:0]=0: IDLE->DONE, res=a, cf=0.
- sll or srl with b[4:0]=n>0: IDLE->SHIFT.
REQ-006 In SHIFT, the working register SHALL shift one bit per cycle (sll: zero-fill at LSB; srl: zero-fill at MSB); the remaining-count register SHALL decrement; after the nth shift the state SHALL go to DONE.
REQ-007 Latency from the accept edge to resp_valid=1 SHALL be 1 cycle for add, sub and zero-amount shifts, and n+1 cycles for an n-bit shift.
REQ-008 add: res=a+b mod 2^32; cf=carry out of bit 31; of=1 when a[31]==b[31] and res[31]!=a[31].
REQ-009 sub: res=a-b mod 2^32; cf=1 when a<b unsigned (borrow); of=1 when a[31]!=b[31] and res[31]!=a[31].
REQ-010 Shifts: cf=last bit shifted out; of=0.
REQ-011 For all operations, zf=1 when res==32'h0.
REQ-012 In DONE, resp_valid=1, and res and the flags SHALL hold stable until an edge with resp_ready=1; on that edge the state SHALL go DONE->IDLE.
REQ-013 Back-to-back operation is not supported: a new request SHALL NOT be accepted on the same edge that retires a response, so the minimum spacing between accepts is 2 cycles.
REQ-014 In IDLE and SHIFT, resp_valid=0; res and the flags SHALL retain the previous response's values and SHALL NOT be checked by consumers.
REQ-015 All outputs SHALL be driven directly from registers or from state decode; there SHALL be no combinational path from any input to any output.

Reset
REQ-016 While rst=1, and asynchronously on its assertion, the block SHALL be in IDLE with req_ready=1, resp_valid=0, res=32'h0, zf=0, of=0, cf=0, and counters cleared.
REQ-017 Reset asserted in SHIFT or DONE SHALL abandon the operation; no response SHALL be produced for it after reset is released.
REQ-018 A request presented during reset SHALL NOT be accepted; the first acceptance SHALL be on the first rising edge after rst deasserts.

Structure
REQ-019 The ctrl encodings alu_add, alu_sub, alu_sll and alu_srl, and the state encodings, SHALL live in the shared alu_const package; the combinational alu and this block SHALL use the same ctrl encodings.
REQ-020 The add/sub datapath (33-bit sum, carry and overflow) SHALL be one sub-module, addsub32, instantiated once; shifting SHALL be done in the top-level FSM datapath.

Verification
REQ-021 The bench SHALL cover these scenarios:
- add a=FFFFFFFF b=FFFFFFFF -> resp_valid 1 cycle after accept; res=FFFFFFFE, cf=1, of=0, zf=0.
- sub a=FFFFFFFF b=FFFFFFFF -> res=00000000, zf=1, cf=0, of=0; then sub a=FFFFFFFF b=F0F0F0F0 -> res=0F0F0F0F, zf=0, cf=0, of=0.
- add a=7FFFFFFF b=00000001 -> res=80000000, of=1, cf=0; sub a=00000000 b=00000001 -> res=FFFFFFFF, cf=1, of=0.
- sll a=FFFFFFFF b=FFFFFFFF (amount 31) -> resp_valid exactly 32 cycles after accept; res=80000000, cf=1, of=0; req_ready=0 throughout.
- Backpressure: srl a=80000000 b=4 with resp_ready held 0 for 5 cycles -> res=08000000 stable and resp_valid=1 until the resp_ready edge, then IDLE; a request presented on the retiring edge is not accepted until the next edge.
- Reset mid-SHIFT (sll by 20, rst asserted after 5 cycles) -> immediately resp_valid=0, req_ready=1, res=0; no response appears after release; the next add 1+2 returns 00000003.
